alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Parametrised multi-cycle execution unit: all base ALU ops plus RV32M multiply/divide.
//  Operands enter through a valid/ready handshake; base ops complete in 1 cycle, and
//  mul/div iterate one bit per cycle. Sits in the EX stage of the multi-cycle core,
//  stalling the pipeline via in_ready/out_valid.
// PARAMETERS
//  XLEN   32   operand/result width (power of 2, >=8)
//  SHW    $clog2(XLEN)   shift-amount width (derived, not overridden)
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     synchronous reset, active-high
//  flush      in   1     abort in-flight op (synchronous)
//  in_valid   in   1     operands/op valid
//  in_ready   out  1     unit can accept (state IDLE)
//  op         in   5     operation code (see BEHAVIOUR)
//  a, b       in   XLEN  operands (two's complement unless op says unsigned)
//  out_valid  out  1     result valid; held until out_ready
//  out_ready  in   1     consumer accepts result
//  result     out  XLEN  result, registered
//  busy       out  1     state != IDLE
// BEHAVIOUR
//  Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA,
//   10 PASSB (LUI), 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
//   Undefined codes behave as base ops with result 0.
//  Reset: state=IDLE, out_valid=0, result=0, busy=0, in_ready=1 in first cycle after reset.
//  FSM: IDLE -> (accept, base op) -> DONE; IDLE -> (accept, mul/div) -> CALC;
//   CALC -> (count==XLEN-1) -> DONE; DONE -> (out_ready) -> IDLE.
//  Accept = in_valid & in_ready at an edge; op/a/b are captured then, so later input changes are ignored.
//  Latency from accept edge T: base op out_valid at T+1; mul/div out_valid at T+XLEN+1.
//  in_ready = (state==IDLE); no overlap. The next op may be accepted in the cycle after the
//   out_valid&out_ready edge.
//  result/out_valid are stable while out_valid=1 & out_ready=0.
//  Shifts use b[SHW-1:0]. SLT is signed, SLTU unsigned; the result is 1 or 0, zero-extended.
//  ADD/SUB/MUL wrap modulo 2^XLEN. MULH/MULHSU/MULHU return the upper XLEN bits of the
//   2*XLEN product with signedness (s*s), (s*u), (u*u).
//  Divide is restoring with unsigned magnitude and sign fix-up in the final cycle.
//   Quotient truncates toward zero, and the remainder takes the dividend's sign.
//  Divide by zero: DIV/DIVU -> all ones; REM/REMU -> a. Same latency as a normal divide
//   (unless the early-out macro below is defined).
//  Signed overflow (a=-2^(XLEN-1), b=-1): DIV -> a, REM -> 0.
//  flush: forces IDLE and out_valid=0 next cycle from any state; any pending result is
//   discarded. If flush and in_valid are both high in IDLE, flush wins and nothing is accepted.
//  rst overrides flush. Reset mid-operation aborts identically.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined:
//   - MUL* with a==0 or b==0, and DIV*/REM* with b==0, skip CALC.
//   - These ops go straight to DONE, so out_valid is at T+1.
//   - Results are unchanged.
//  Not defined: all mul/div ops take the fixed XLEN+1 latency.
// TESTING
//  ADD a=5 b=-3, out_ready=1 -> result=2, out_valid 1 cycle after accept, in_ready back next cycle
//  MULH a=b=0x80000000 -> 0x40000000 at accept+33; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE
//  DIV a=-7 b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000, REM -> 0
//  DIVU a=9 b=0 -> 0xFFFFFFFF, REMU -> 9; latency 33 without macro, 1 with MULDIV_EARLY_OUT_EN
//  out_ready held low 5 cycles after out_valid -> result/out_valid stable, in_ready=0 throughout
//  rst (or flush) asserted 10 cycles into DIV -> next cycle IDLE, out_valid=0, result=0 (rst), next ADD correct

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle EX-stage unit with base ALU ops and RV32M mul/div.
// Base ops finish in one cycle; mul/div iterate one bit per cycle over unsigned
// magnitudes with a sign fix-up on the last iteration.
// Optional macro MULDIV_EARLY_OUT_EN: trivial mul (zero operand) and divide-by-zero
// skip the iterative phase and complete like a base op.
module alu_muldiv_seq #(
  parameter int unsigned XLEN = 32,
  localparam int unsigned SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [4:0] OpAdd    = 5'd0;
  localparam logic [4:0] OpSub    = 5'd1;
  localparam logic [4:0] OpAnd    = 5'd2;
  localparam logic [4:0] OpOr     = 5'd3;
  localparam logic [4:0] OpXor    = 5'd4;
  localparam logic [4:0] OpSlt    = 5'd5;
  localparam logic [4:0] OpSltu   = 5'd6;
  localparam logic [4:0] OpSll    = 5'd7;
  localparam logic [4:0] OpSrl    = 5'd8;
  localparam logic [4:0] OpSra    = 5'd9;
  localparam logic [4:0] OpPassB  = 5'd10;
  localparam logic [4:0] OpMul    = 5'd16;
  localparam logic [4:0] OpMulh   = 5'd17;
  localparam logic [4:0] OpMulhsu = 5'd18;
  localparam logic [4:0] OpMulhu  = 5'd19;
  localparam logic [4:0] OpDiv    = 5'd20;
  localparam logic [4:0] OpDivu   = 5'd21;
  localparam logic [4:0] OpRem    = 5'd22;
  localparam logic [4:0] OpRemu   = 5'd23;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e state_q, state_d;

  logic [4:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic            bzero_q;
  logic            neg_q;
  logic [XLEN-1:0] hi_q, lo_q, opnd_q;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] result_q;

  logic            accept, is_md, is_mul, is_div, fast, last;
  logic [XLEN-1:0] base_res, fast_res, md_res;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] hi_n, lo_n;
  logic [XLEN:0]   mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [SHW-1:0]  shamt;

  assign accept = in_valid & in_ready & ~flush;
  assign is_md  = (op[4:3] == 2'b10);
  assign is_mul = (op[4:2] == 3'b100);
  assign is_div = (op[4:2] == 3'b101);
  assign last   = (cnt_q == SHW'(XLEN - 1));
  assign shamt  = b[SHW-1:0];

`ifdef MULDIV_EARLY_OUT_EN
  // Zero multiplier operand or zero divisor: result known without iterating
  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    if (is_mul && (a == '0 || b == '0)) begin
      fast     = 1'b1;
      fast_res = '0;
    end else if (is_div && b == '0) begin
      fast     = 1'b1;
      fast_res = (op == OpDiv || op == OpDivu) ? '1 : a;
    end
  end
`else
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif

  // Single-cycle ALU result; undefined codes yield zero
  always_comb begin
    base_res = '0;
    case (op)
      OpAdd:   base_res = a + b;
      OpSub:   base_res = a - b;
      OpAnd:   base_res = a & b;
      OpOr:    base_res = a | b;
      OpXor:   base_res = a ^ b;
      OpSlt:   base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OpSltu:  base_res = {{(XLEN-1){1'b0}}, (a < b)};
      OpSll:   base_res = a << shamt;
      OpSrl:   base_res = a >> shamt;
      OpSra:   base_res = $signed(a) >>> shamt;
      OpPassB: base_res = b;
      default: base_res = '0;
    endcase
  end

  // Operand signedness and magnitudes for the iterative datapath
  always_comb begin
    a_signed = (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
    b_signed = (op == OpMulh) || (op == OpDiv) || (op == OpRem);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
  end

  // One shift-add (mul) or restoring-subtract (div) step; hi=acc/rem, lo=mplier/quotient
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {XLEN{1'b0}})};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    hi_n      = hi_q;
    lo_n      = lo_q;
    if (op_q[2] == 1'b0) begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end else if (!div_trial[XLEN]) begin
      hi_n = div_trial[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_n = div_shift[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up and divide-by-zero selection applied on the final iteration
  always_comb begin
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    md_res = '0;
    case (op_q)
      OpMul:                    md_res = prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: md_res = prod_s[2*XLEN-1:XLEN];
      OpDiv, OpDivu:            md_res = bzero_q ? '1 : (neg_q ? -lo_n : lo_n);
      OpRem, OpRemu:            md_res = bzero_q ? a_q : (neg_q ? -hi_n : hi_n);
      default:                  md_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; flush aborts from any state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = (is_md && !fast) ? StCalc : StDone;
      StCalc: if (last) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q != StIdle);
    out_valid = (state_q == StDone);
  end

  // Operand capture, iteration registers and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      a_q      <= '0;
      bzero_q  <= 1'b0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= op;
      a_q     <= a;
      bzero_q <= (b == '0);
      // Quotient sign follows both operands, remainder sign follows the dividend
      neg_q   <= (op == OpRem) ? a_neg : (a_neg ^ b_neg);
      hi_q    <= '0;
      lo_q    <= a_mag;
      opnd_q  <= b_mag;
      cnt_q   <= '0;
      if (!is_md) result_q <= base_res;
      else if (fast) result_q <= fast_res;
    end else if (state_q == StCalc && !flush) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + SHW'(1);
      if (last) result_q <= md_res;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomised scoreboard bench for alu_muldiv_seq (XLEN=32).
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  alu_muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference results straight from the ISA definitions using 64-bit arithmetic
  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    r = '0;
    case (o)
      5'd0:  r = x + y;
      5'd1:  r = x - y;
      5'd2:  r = x & y;
      5'd3:  r = x | y;
      5'd4:  r = x ^ y;
      5'd5:  r = (sx < sy) ? 32'd1 : 32'd0;
      5'd6:  r = (ux < uy) ? 32'd1 : 32'd0;
      5'd7:  r = x << y[4:0];
      5'd8:  r = x >> y[4:0];
      5'd9:  r = 32'(sx >>> y[4:0]);
      5'd10: r = y;
      5'd16: begin p = 64'(ux * uy); r = p[31:0]; end
      5'd17: begin p = 64'(sx * sy); r = p[63:32]; end
      5'd18: begin p = 64'(sx * uy); r = p[63:32]; end
      5'd19: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
      5'd20: r = (y == 0) ? 32'hFFFF_FFFF : 32'(sx / sy);
      5'd21: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      5'd22: r = (y == 0) ? x : 32'(sx % sy);
      5'd23: r = (y == 0) ? x : x % y;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [4:0] o, input logic [31:0] x,
                                 input logic [31:0] y);
    if (o < 5'd16 || o > 5'd23) return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (o <= 5'd19 && (x == 0 || y == 0)) return 1;
    if (o >= 5'd20 && y == 0) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, check latency and hold behaviour, then release via out_ready
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int hold);
    logic [31:0] e;
    int lat;
    e = model(o, x, y);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    chk($sformatf("latency_op%0d", o), 32'(lat), 32'(exp_lat(o, x, y)));
    chk("in_ready_busy", in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_result", result, e);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after", in_ready, 1'b1);
    chk("out_valid_after", out_valid, 1'b0);
  endtask

  // Start a DIV, then abort it 10 cycles in with flush or reset
  task automatic abort(input bit use_rst);
    @(posedge clk);
    #1;
    in_valid = 1'b1; op = 5'd20; a = 32'hFFFF_FFF9; b = 32'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    if (use_rst) chk("abort_result", result, 32'h0);
    repeat (40) @(negedge clk);
    chk("abort_no_late_valid", out_valid, 1'b0);
    issue(5'd0, 32'd5, 32'hFFFF_FFFD, 0);
  endtask

  // Scoreboard monitor: compare on every completed output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h expected no output", result);
      end else begin
        chk("result", result, exp_q.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ops[23] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 16, 17, 18, 19, 20, 21, 22, 23,
                    11, 15, 24, 31};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);

    issue(5'd0,  32'd5,        32'hFFFF_FFFD, 0);
    issue(5'd17, 32'h8000_0000, 32'h8000_0000, 0);
    issue(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue(5'd20, 32'hFFFF_FFF9, 32'd2, 0);
    issue(5'd22, 32'hFFFF_FFF9, 32'd2, 0);
    issue(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(5'd21, 32'd9, 32'd0, 0);
    issue(5'd23, 32'd9, 32'd0, 0);
    issue(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    issue(5'd9,  32'h8000_0010, 32'h0000_0024, 5);

    abort(1'b0);
    abort(1'b1);

    // flush wins over in_valid in IDLE
    @(posedge clk);
    #1;
    in_valid = 1'b1; flush = 1'b1; op = 5'd0; a = 32'd1; b = 32'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_vs_valid_busy", busy, 1'b0);
    chk("flush_vs_valid_in_ready", in_ready, 1'b1);

    for (int n = 0; n < 200; n++) begin
      issue(5'(ops[$urandom_range(0, 22)]), rnd_operand(), rnd_operand(),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
